// File: rtl/pin_entry_if.sv
// Switch inputs and code handshake between the PIN entry front end and its consumer.
interface pin_entry_if;
    logic [3:0]  digit_sw;
    logic        enter_sw;
    logic        clear_sw;
    logic        code_ack;
    logic [15:0] code;
    logic        code_valid;
    logic [2:0]  digit_count;
    logic        digit_err;
    logic        timeout;

    modport master (
        output digit_sw, enter_sw, clear_sw, code_ack,
        input  code, code_valid, digit_count, digit_err, timeout
    );

    modport slave (
        input  digit_sw, enter_sw, clear_sw, code_ack,
        output code, code_valid, digit_count, digit_err, timeout
    );
endinterface

// File: rtl/pin_entry.sv
// PIN entry front end: debounces enter/clear, collects four BCD digits and presents
// the finished code with a valid/ack handshake.
module pin_entry #(
    parameter int unsigned DEB_CYCLES     = 1000000,
    parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
    input logic        clk,
    input logic        rst,
    pin_entry_if.slave pin_if
);
    localparam int unsigned DebMax = (DEB_CYCLES > 0) ? DEB_CYCLES - 1 : 0;
    localparam int unsigned DebW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned TmoMax = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int unsigned TmoW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StCollect, StPresent} state_e;

    // Channel 0 is enter, channel 1 is clear.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            deb_q, deb_d;
    logic [1:0]            armed_q, armed_d;
    logic [1:0]            vld_q;
    logic [1:0]            rise;
    logic [1:0][DebW-1:0]  dcnt_q, dcnt_d;

    state_e                state_q, state_d;
    logic [15:0]           code_q, code_d;
    logic [2:0]            count_q, count_d;
    logic                  err_q, err_d;
    logic                  tmo_q, tmo_d;
    logic [TmoW-1:0]       tcnt_q, tcnt_d;

    logic                  enter_rise, clear_rise, digit_ok, tmo_hit;

    // An edge is only reported once the synchronized level has been seen low after
    // reset, so a switch held through reset release does not count as a press.
    always_comb begin
        deb_d   = deb_q;
        dcnt_d  = '0;
        rise    = '0;
        armed_d = armed_q | ({2{vld_q[1]}} & ~sync2_q);
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] >= DebW'(DebMax)) begin
                    deb_d[i] = sync2_q[i];
                    rise[i]  = sync2_q[i] & armed_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            armed_q <= '0;
            vld_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            sync1_q <= {pin_if.clear_sw, pin_if.enter_sw};
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            armed_q <= armed_d;
            vld_q   <= {vld_q[0], 1'b1};
            dcnt_q  <= dcnt_d;
        end
    end

    assign enter_rise = rise[0];
    assign clear_rise = rise[1];
    assign digit_ok   = (pin_if.digit_sw <= 4'd9);
    assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tcnt_q == TmoW'(TmoMax));

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        count_d = count_q;
        err_d   = 1'b0;
        tmo_d   = 1'b0;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            StIdle, StCollect: begin
                if (clear_rise) begin
                    code_d  = '0;
                    count_d = '0;
                    tcnt_d  = '0;
                    state_d = StIdle;
                end else if (enter_rise && digit_ok) begin
                    code_d  = {code_q[11:0], pin_if.digit_sw};
                    count_d = count_q + 3'd1;
                    tcnt_d  = '0;
                    state_d = (count_q == 3'd3) ? StPresent : StCollect;
                end else begin
                    err_d = enter_rise;
                    if (state_q == StCollect && TIMEOUT_CYCLES != 0) begin
                        if (tmo_hit) begin
                            code_d  = '0;
                            count_d = '0;
                            tcnt_d  = '0;
                            tmo_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                end
            end
            StPresent: begin
                if (pin_if.code_ack) begin
                    code_d  = '0;
                    count_d = '0;
                    tcnt_d  = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            code_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            count_q <= count_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign pin_if.code        = code_q;
    assign pin_if.code_valid  = (state_q == StPresent);
    assign pin_if.digit_count = count_q;
    assign pin_if.digit_err   = err_q;
    assign pin_if.timeout     = tmo_q;
endmodule

// File: doc/pin_entry.md
PIN_ENTRY -- requirements
Module: pin_entry

Upstream stage of the password FSM: debounces the entry switches, collects four BCD digits and hands the finished code over with a valid/ack handshake.

Interface
REQ-001 SHALL have parameter: DEB_CYCLES, 1000000, consecutive stable cycles before a debounced input changes (20 ms at 50 MHz).
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, 250000000, idle cycles after the last accepted digit before a partial entry is discarded; 0 disables the timeout.
REQ-003 SHALL have port: clk  in  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port: digit_sw  in  4  digit value, sampled when enter is accepted.
REQ-006 SHALL have port: enter_sw  in  1  raw enter switch; the action is its debounced rising edge.
REQ-007 SHALL have port: clear_sw  in  1  raw clear switch; the action is its debounced rising edge.
REQ-008 SHALL have port: code_ack  in  1  consumer accepts code; only meaningful while code_valid=1.
REQ-009 SHALL have port: code  out  16  BCD digits; first-entered digit in [15:12], newest digit in [3:0].
REQ-010 SHALL have port: code_valid  out  1  high while a complete 4-digit code is presented.
REQ-011 SHALL have port: digit_count  out  3  number of digits held, 0..4.
REQ-012 SHALL have port: digit_err  out  1  one-cycle pulse when enter is attempted with digit_sw>9.
REQ-013 SHALL have port: timeout  out  1  one-cycle pulse when a partial entry is discarded by timeout.

Function
REQ-014 SHALL pass enter_sw and clear_sw each through a 2-flop synchronizer followed by an independent debouncer.
REQ-015 SHALL change each debounced level only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any intermediate match restarts that count.
REQ-016 SHALL generate enter_rise and clear_rise as single-cycle pulses on each 0->1 debounced transition.
REQ-017 SHALL implement states: IDLE (count=0), COLLECT (count 1..3) and PRESENT (count=4, code_valid=1).
REQ-018 SHALL, in IDLE or COLLECT on enter_rise with digit_sw<=9: shift code left 4 bits, insert digit_sw into [3:0] and increment digit_count; results are visible on the next cycle.
REQ-019 SHALL enter PRESENT on the cycle the fourth digit is stored, with code_valid=1 in that same cycle.
REQ-020 SHALL, on enter_rise with digit_sw>9 in IDLE or COLLECT: pulse digit_err for one cycle and leave code and digit_count unchanged.
REQ-021 SHALL, in PRESENT: keep code and code_valid stable, and ignore enter_rise, clear_rise and timeout, until code_ack=1.
REQ-022 SHALL, in PRESENT with code_ack=1: set code=0, digit_count=0 and code_valid=0, and go to IDLE on the next cycle.
REQ-023 SHALL ignore code_ack outside PRESENT.
REQ-024 SHALL, on clear_rise in IDLE or COLLECT: set code=0 and digit_count=0 and go to IDLE.
REQ-025 SHALL give clear_rise priority over a simultaneous enter_rise; that digit is dropped and no digit_err is raised.
REQ-026 SHALL run a timeout counter only in COLLECT, restarting it at 0 on each accepted digit.
REQ-027 SHALL, when the timeout counter reaches TIMEOUT_CYCLES: clear code and digit_count, go to IDLE and pulse timeout once.
REQ-028 SHALL let a simultaneous clear_rise win over the timeout, with no timeout pulse.
REQ-029 SHALL let a simultaneous accepted digit win over the timeout, restarting the timeout counter.
REQ-030 SHALL keep the timeout counter wide enough for TIMEOUT_CYCLES without wrap-around.
REQ-031 SHALL keep the debounce counters saturating, never wrapping.

Reset
REQ-032 SHALL, while rst=1 at a clock edge: set code=0, code_valid=0, digit_count=0, digit_err=0, timeout=0 and state=IDLE.
REQ-033 SHALL, on that same reset: clear synchronizers, debounced levels, debounce counters and the timeout counter.
REQ-034 SHALL apply reset mid-entry or mid-PRESENT in the same cycle, dropping any pending code without an ack.
REQ-035 SHALL NOT report a held-high enter_sw at reset release as an edge until it has gone low and high again.

Verification (DEB_CYCLES=4, TIMEOUT_CYCLES=50)
REQ-036 SHALL cover: enter digits 1,2,3,4 cleanly -> code=16'h1234, digit_count=4, code_valid=1 and held; code_ack for one cycle -> next cycle code=0, code_valid=0, digit_count=0.
REQ-037 SHALL cover: enter_sw bouncing with high pulses of 3 cycles, then stable high -> exactly one digit accepted, 2+4 cycles after the stable high begins.
REQ-038 SHALL cover: digit_sw=4'hA then enter -> digit_err high for exactly 1 cycle, digit_count unchanged; a fifth enter during PRESENT -> code unchanged.
REQ-039 SHALL cover: two digits entered, then 50 idle cycles -> timeout pulse, code=0, digit_count=0; clear_rise coinciding with expiry -> no timeout pulse.
REQ-040 SHALL cover: clear_rise coinciding with enter_rise at count=2 -> count=0, no digit stored, no digit_err.
REQ-041 SHALL cover: rst asserted in PRESENT, then released with enter_sw held high -> all outputs 0, no digit accepted until enter_sw toggles.
